// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM state type and op-decoding helpers.
package muldiv_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_MUL    = 3'd0;
  localparam op_t OP_MULH   = 3'd1;
  localparam op_t OP_MULHSU = 3'd2;
  localparam op_t OP_MULHU  = 3'd3;
  localparam op_t OP_DIV    = 3'd4;
  localparam op_t OP_DIVU   = 3'd5;
  localparam op_t OP_REM    = 3'd6;
  localparam op_t OP_REMU   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  function automatic logic is_div(input op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem(input op_t op);
    return op[2] & op[1];
  endfunction

  // MUL returns the low half, which is sign-agnostic, so it is treated as unsigned.
  function automatic logic is_signed_a(input op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// E-stage request/response bundle between the pipeline (master) and the
// multiply/divide unit (slave).
interface muldiv_if import muldiv_pkg::*; #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) ();

  logic               start;
  op_t                op;
  logic [XLEN-1:0]    a;
  logic [XLEN-1:0]    b;
  logic [RADDR_W-1:0] rd_in;
  logic               flush;
  logic               busy;
  logic               stall;
  logic               done;
  logic [XLEN-1:0]    result;
  logic [RADDR_W-1:0] rd_out;

  modport master (
    output start, op, a, b, rd_in, flush,
    input  busy, stall, done, result, rd_out
  );

  modport slave (
    input  start, op, a, b, rd_in, flush,
    output busy, stall, done, result, rd_out
  );

endinterface

// File: rtl/muldiv_iter_core.sv
// Shared datapath for the iterative multiply/divide: 2*XLEN shift register,
// one XLEN+1 adder/subtractor and the bit counter. mode=0 shift-add, mode=1 restoring divide.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              mode,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [2*XLEN-1:0] acc,
  output logic              last
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  operand;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  hi;
  logic [XLEN-1:0]  lo;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    sum;

  assign hi = acc[2*XLEN-1:XLEN];
  assign lo = acc[XLEN-1:0];

  // Divide shifts the next dividend bit into the partial remainder before subtracting.
  assign shifted = mode ? {hi, lo[XLEN-1]} : {1'b0, hi};
  assign sum     = mode ? (shifted - {1'b0, operand}) : (shifted + {1'b0, operand});
  assign last    = (count == CNT_W'(XLEN - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      operand <= '0;
      count   <= '0;
    end else if (load) begin
      acc     <= {{XLEN{1'b0}}, op_a};
      operand <= op_b;
      count   <= '0;
    end else if (step) begin
      count <= count + CNT_W'(1);
      if (mode) begin
        // sum[XLEN] is the borrow: restore by keeping the un-subtracted value.
        if (sum[XLEN])
          acc <= {shifted[XLEN-1:0], lo[XLEN-2:0], 1'b0};
        else
          acc <= {sum[XLEN-1:0], lo[XLEN-2:0], 1'b1};
      end else begin
        if (lo[0])
          acc <= {sum, lo[XLEN-1:1]};
        else
          acc <= {1'b0, hi, lo[XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the E stage: FSM, operand latching, sign handling
// and special cases. Optional MULDIV_FAST_MUL_EN gives MUL* ops a combinational multiplier.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t             state;
  op_t                op_q;
  logic [XLEN-1:0]    a_q;
  logic [XLEN-1:0]    b_q;
  logic [RADDR_W-1:0] rd_q;
  logic               busy_q;
  logic               done_q;
  logic [XLEN-1:0]    result_q;
  logic [RADDR_W-1:0] rd_out_q;

  logic               neg_a;
  logic               neg_b;
  logic               neg_res;
  logic [XLEN-1:0]    abs_a;
  logic [XLEN-1:0]    abs_b;
  logic               b_zero;
  logic               overflow;
  logic               special;
  logic [XLEN-1:0]    special_val;
  logic [2*XLEN-1:0]  acc;
  logic               last;
  logic [2*XLEN-1:0]  mul_prod;
  logic [XLEN-1:0]    div_sel;
  logic [XLEN-1:0]    fix_val;

  assign neg_a    = is_signed_a(op_q) & a_q[XLEN-1];
  assign neg_b    = is_signed_b(op_q) & b_q[XLEN-1];
  assign abs_a    = neg_a ? -a_q : a_q;
  assign abs_b    = neg_b ? -b_q : b_q;
  // The remainder follows the dividend; quotients and products follow both signs.
  assign neg_res  = is_rem(op_q) ? neg_a : (neg_a ^ neg_b);

  assign b_zero      = (b_q == '0);
  assign overflow    = ((op_q == OP_DIV) || (op_q == OP_REM)) && (a_q == MIN_NEG) && (b_q == '1);
  assign special     = is_div(op_q) && (b_zero || overflow);
  assign special_val = b_zero ? (is_rem(op_q) ? a_q : '1)
                              : (is_rem(op_q) ? '0 : MIN_NEG);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] ext_a;
  logic [2*XLEN-1:0] ext_b;
  assign ext_a    = {{XLEN{neg_a}}, a_q};
  assign ext_b    = {{XLEN{neg_b}}, b_q};
  assign mul_prod = ext_a * ext_b;
`else
  assign mul_prod = neg_res ? -acc : acc;
`endif

  assign div_sel = is_rem(op_q) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
  assign fix_val = is_div(op_q) ? (neg_res ? -div_sel : div_sel)
                                : ((op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN]);

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (state == S_PREP),
    .step  ((state == S_RUN) && !bus.flush),
    .mode  (is_div(op_q)),
    .op_a  (abs_a),
    .op_b  (abs_b),
    .acc   (acc),
    .last  (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            op_q   <= bus.op;
            a_q    <= bus.a;
            b_q    <= bus.b;
            rd_q   <= bus.rd_in;
            busy_q <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
            state  <= is_div(bus.op) ? S_PREP : S_FIX;
`else
            state  <= S_PREP;
`endif
          end
        end
        S_PREP: begin
          if (bus.flush) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else if (special) begin
            result_q <= special_val;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= S_DONE;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else if (last) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (bus.flush) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            result_q <= fix_val;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          // start is still the completed instruction here, so it is never re-accepted.
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;
  assign bus.stall  = (bus.start && (state == S_IDLE)) || busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit plus flush/reset sequences.
// Expected MUL latency follows MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int L_MUL = 2;
`else
  localparam int L_MUL = 35;
`endif
  localparam int L_DIV = 35;
  localparam int L_SPC = 2;
  localparam int NVEC  = 18;

  typedef struct {
    string       name;
    op_t         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  vec_t        vecs[NVEC];
  logic [31:0] last_exp;
  logic [4:0]  last_rd;

  muldiv_if #(.XLEN(32), .RADDR_W(5)) bus ();

  muldiv_unit #(.XLEN(32), .RADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    else
      passes++;
  endtask

  task automatic applyStimulus(input op_t op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.rd_in = rd;
  endtask

  // Cycle index of done relative to the accept cycle (cycle 0); -1 on timeout.
  task automatic waitDone(output int lat, output bit stall_ok);
    lat      = -1;
    stall_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = c;
        if (bus.stall || bus.busy) stall_ok = 1'b0;
        break;
      end
      if (!bus.stall || !bus.busy) stall_ok = 1'b0;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  stall_ok;
    bit  seen_done;

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = OP_MUL;
    bus.a     = '0;
    bus.b     = '0;
    bus.rd_in = '0;
    bus.flush = 1'b0;

    vecs[0]  = '{"mul_7x6",      OP_MUL,    32'd7,        32'd6,        5'd5,  32'd42,        L_MUL};
    vecs[1]  = '{"mulh_min",     OP_MULH,   32'h80000000, 32'h80000000, 5'd1,  32'h40000000,  L_MUL};
    vecs[2]  = '{"mulhu_max",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE,  L_MUL};
    vecs[3]  = '{"mulhsu_m1",    OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF,  L_MUL};
    vecs[4]  = '{"mul_neg",      OP_MUL,    32'hFFFFFFFD, 32'd5,        5'd4,  32'hFFFFFFF1,  L_MUL};
    vecs[5]  = '{"div_m7_2",     OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD,  L_DIV};
    vecs[6]  = '{"rem_m7_2",     OP_REM,    32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF,  L_DIV};
    vecs[7]  = '{"divu_100_7",   OP_DIVU,   32'd100,      32'd7,        5'd8,  32'd14,        L_DIV};
    vecs[8]  = '{"remu_100_7",   OP_REMU,   32'd100,      32'd7,        5'd9,  32'd2,         L_DIV};
    vecs[9]  = '{"divu_by0",     OP_DIVU,   32'h1234,     32'd0,        5'd10, 32'hFFFFFFFF,  L_SPC};
    vecs[10] = '{"remu_by0",     OP_REMU,   32'h1234,     32'd0,        5'd11, 32'h1234,      L_SPC};
    vecs[11] = '{"div_ovf",      OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000,  L_SPC};
    vecs[12] = '{"rem_ovf",      OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h0,         L_SPC};
    vecs[13] = '{"rem_7_m2",     OP_REM,    32'd7,        32'hFFFFFFFE, 5'd14, 32'd1,         L_DIV};
    vecs[14] = '{"div_7_m2",     OP_DIV,    32'd7,        32'hFFFFFFFE, 5'd15, 32'hFFFFFFFD,  L_DIV};
    vecs[15] = '{"rem_m5_by0",   OP_REM,    32'hFFFFFFFB, 32'd0,        5'd16, 32'hFFFFFFFB,  L_SPC};
    vecs[16] = '{"mulh_m2x3",    OP_MULH,   32'hFFFFFFFE, 32'd3,        5'd17, 32'hFFFFFFFF,  L_MUL};
    vecs[17] = '{"divu_max_1",   OP_DIVU,   32'hFFFFFFFF, 32'd1,        5'd18, 32'hFFFFFFFF,  L_DIV};

    repeat (2) @(negedge clk);
    checkOutput("reset_busy",   64'(bus.busy),   64'd0);
    checkOutput("reset_done",   64'(bus.done),   64'd0);
    checkOutput("reset_result", 64'(bus.result), 64'd0);
    checkOutput("reset_rd",     64'(bus.rd_out), 64'd0);
    checkOutput("reset_stall",  64'(bus.stall),  64'd0);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
      waitDone(lat, stall_ok);
      checkOutput({vecs[i].name, "_latency"}, 64'(lat),          64'(vecs[i].lat));
      checkOutput({vecs[i].name, "_result"},  64'(bus.result),   64'(vecs[i].exp));
      checkOutput({vecs[i].name, "_rd"},      64'(bus.rd_out),   64'(vecs[i].rd));
      checkOutput({vecs[i].name, "_stall"},   64'(stall_ok),     64'd1);
      last_exp = vecs[i].exp;
      last_rd  = vecs[i].rd;
    end

    // start together with flush in IDLE must not be accepted
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'd50;
    bus.b     = 32'd5;
    bus.rd_in = 5'd19;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checkOutput("idle_flush_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    checkOutput("idle_flush_busy2", 64'(bus.busy), 64'd0);

    // flush mid-RUN: op vanishes, previous result/rd retained
    applyStimulus(OP_DIVU, 32'd1000, 32'd3, 5'd21);
    repeat (11) @(negedge clk);
    bus.flush = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("flush_busy",  64'(bus.busy),  64'd0);
    checkOutput("flush_stall", 64'(bus.stall), 64'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    checkOutput("flush_no_done", 64'(seen_done),  64'd0);
    checkOutput("flush_result",  64'(bus.result), 64'(last_exp));
    checkOutput("flush_rd",      64'(bus.rd_out), 64'(last_rd));

    applyStimulus(OP_DIVU, 32'd1000, 32'd3, 5'd22);
    waitDone(lat, stall_ok);
    checkOutput("after_flush_latency", 64'(lat),        64'(L_DIV));
    checkOutput("after_flush_result",  64'(bus.result), 64'd333);
    checkOutput("after_flush_rd",      64'(bus.rd_out), 64'd22);

    // asynchronous reset mid-RUN clears outputs immediately
    applyStimulus(OP_DIV, 32'hFFFFFF9C, 32'd7, 5'd23);
    repeat (6) @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    #1;
    checkOutput("midreset_busy",   64'(bus.busy),   64'd0);
    checkOutput("midreset_done",   64'(bus.done),   64'd0);
    checkOutput("midreset_result", 64'(bus.result), 64'd0);
    checkOutput("midreset_rd",     64'(bus.rd_out), 64'd0);
    checkOutput("midreset_stall",  64'(bus.stall),  64'd0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(OP_MUL, 32'd3, 32'd3, 5'd24);
    waitDone(lat, stall_ok);
    checkOutput("post_reset_latency", 64'(lat),        64'(L_MUL));
    checkOutput("post_reset_result",  64'(bus.result), 64'd9);
    checkOutput("post_reset_rd",      64'(bus.rd_out), 64'd24);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
